toggle_handshake_rx: RTL and testbench

//  Receiving end of the two-phase (toggle) handshake driven by our T flip-flop senders.
//  - Sender signals a new word by toggling req_tgl with req_data held stable.
//  - Block detects the toggle, captures the word into a small FIFO and toggles ack_tgl.
//  - Words drain on a valid/ready stream to downstream logic.
//  - Sits between any toggle-signalling producer and a ready/valid consumer in the same clock domain.

---
 rtl/toggle_hs_pkg.sv | 17 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/toggle_handshake_rx.sv | 57 +++++
 tb/tb_toggle_handshake_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_hs_pkg.sv
// Shared constants for the toggle-handshake blocks: default word width and FIFO depth,
// plus a constant-evaluable ceil(log2) used to size FIFO pointers.
package toggle_hs_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one extra counter bit so full and empty stay distinguishable.
// The caller must not push when full or pop when empty.
module sync_fifo
  import toggle_hs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;

  // Counters wrap naturally; the low AW bits address the storage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + (AW+1)'(1);
      if (pop)  rd_cnt <= rd_cnt + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_cnt[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_cnt[AW-1:0]];
  assign fill  = wr_cnt - rd_cnt;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiver for two-phase toggle requests: captures each pending word into a FIFO,
// answers by toggling ack_tgl, and drains the FIFO on a valid/ready stream.
module toggle_handshake_rx
  import toggle_hs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] req_data,
  output logic             ack_tgl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      fill
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic req_seen;
  logic pending;
  logic push;
  logic pop;

  // Full is judged on the occupancy at the start of the cycle, so a same-cycle pop
  // does not let a waiting request in until the following edge.
  assign pending   = req_tgl ^ req_seen;
  assign push      = pending && (fill != FULL_LEVEL);
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign ack_tgl   = req_seen;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_seen <= 1'b0;
    end else if (push) begin
      req_seen <= ~req_seen;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .wdata (req_data),
    .pop   (pop),
    .rdata (out_data),
    .fill  (fill)
  );

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: a queue scoreboard is loaded as the sender
// toggles and drained by a monitor that checks every word leaving the stream.
module tb_toggle_handshake_rx;

  logic       Clk;
  logic       Reset;
  logic       req_tgl;
  logic [7:0] req_data;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] fill;

  int tests_run;
  int tests_failed;
  int pop_count;
  logic [7:0] sb[$];

  toggle_handshake_rx #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_tgl   (req_tgl),
    .req_data  (req_data),
    .ack_tgl   (ack_tgl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fill      (fill)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change 1 time unit after each rising edge; the monitor looks at the
  // half-cycle point, where a handshake seen will be taken on the next edge.
  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      tests_run++;
      pop_count++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL pop_unexpected: got word %h, expected no word", out_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (out_data !== exp) begin
          tests_failed++;
          $display("[TB] FAIL pop_data: got %h, expected %h", out_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Waits for the previous request to be acknowledged, then toggles with a new word.
  task automatic send_word(input logic [7:0] data);
    int waited;
    waited = 0;
    while (ack_tgl !== req_tgl && waited < 300) begin
      tick();
      waited++;
    end
    if (ack_tgl !== req_tgl) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ack_timeout: ack_tgl=%b, expected %b", ack_tgl, req_tgl);
    end
    req_data = data;
    req_tgl  = ~req_tgl;
    sb.push_back(data);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 20) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (fill !== 3'd0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: fill=%0d pending=%0d, expected 0 and 0", fill, sb.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; req_tgl = 1'b0; req_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    tests_run += 3;
    if (ack_tgl !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_ack: got %b, expected 0", ack_tgl); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid); end
    if (fill !== 3'd0)      begin tests_failed++; $display("[TB] FAIL reset_fill: got %0d, expected 0", fill); end
    Reset = 1'b0;
    tick();
    send_word(8'h11);
    tick();
    tests_run += 2;
    if (fill !== 3'd1)    begin tests_failed++; $display("[TB] FAIL pre_reset_fill: got %0d, expected 1", fill); end
    if (ack_tgl !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset_ack: got %b, expected 1", ack_tgl); end
    // Asynchronous reset mid-cycle must clear everything before the next edge.
    #2;
    Reset = 1'b1; req_tgl = 1'b0;
    sb.delete();
    #1;
    tests_run += 3;
    if (ack_tgl !== 1'b0)   begin tests_failed++; $display("[TB] FAIL async_reset_ack: got %b, expected 0", ack_tgl); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset_valid: got %b, expected 0", out_valid); end
    if (fill !== 3'd0)      begin tests_failed++; $display("[TB] FAIL async_reset_fill: got %0d, expected 0", fill); end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int pops_before;
    pops_before = pop_count;
    out_ready = 1'b0;
    send_word(8'hA5);
    tests_run++;
    if (ack_tgl !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_ack_early: got %b, expected 0", ack_tgl); end
    tick();
    tests_run += 4;
    if (ack_tgl !== 1'b1)    begin tests_failed++; $display("[TB] FAIL single_ack: got %b, expected 1", ack_tgl); end
    if (out_valid !== 1'b1)  begin tests_failed++; $display("[TB] FAIL single_valid: got %b, expected 1", out_valid); end
    if (out_data !== 8'hA5)  begin tests_failed++; $display("[TB] FAIL single_data: got %h, expected a5", out_data); end
    if (fill !== 3'd1)       begin tests_failed++; $display("[TB] FAIL single_fill: got %0d, expected 1", fill); end
    out_ready = 1'b1;
    tick();
    tests_run += 2;
    if (fill !== 3'd0)               begin tests_failed++; $display("[TB] FAIL single_pop_fill: got %0d, expected 0", fill); end
    if (pop_count != pops_before + 1) begin tests_failed++; $display("[TB] FAIL single_pop_count: got %0d, expected %0d", pop_count - pops_before, 1); end
    // Ready while empty must be ignored.
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (fill !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL empty_ready: fill=%0d valid=%b, expected 0 and 0", fill, out_valid);
    end
  endtask

  task automatic test_full();
    logic held_ack;
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      send_word(8'(w));
      tick();
      tests_run++;
      if (ack_tgl !== req_tgl) begin
        tests_failed++;
        $display("[TB] FAIL full_ack_word%0d: got %b, expected %b", w, ack_tgl, req_tgl);
      end
    end
    held_ack = ack_tgl;
    send_word(8'h05);
    tick(); tick();
    tests_run += 2;
    if (ack_tgl !== held_ack) begin tests_failed++; $display("[TB] FAIL full_ack_held: got %b, expected %b", ack_tgl, held_ack); end
    if (fill !== 3'd4)        begin tests_failed++; $display("[TB] FAIL full_fill: got %0d, expected 4", fill); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run += 2;
    if (ack_tgl !== held_ack) begin tests_failed++; $display("[TB] FAIL full_pop_edge_ack: got %b, expected %b", ack_tgl, held_ack); end
    if (fill !== 3'd3)        begin tests_failed++; $display("[TB] FAIL full_pop_edge_fill: got %0d, expected 3", fill); end
    tick();
    tests_run += 2;
    if (ack_tgl !== ~held_ack) begin tests_failed++; $display("[TB] FAIL full_late_ack: got %b, expected %b", ack_tgl, ~held_ack); end
    if (fill !== 3'd4)         begin tests_failed++; $display("[TB] FAIL full_late_fill: got %0d, expected 4", fill); end
    drain();
  endtask

  task automatic test_concurrent();
    out_ready = 1'b0;
    send_word(8'h21); tick();
    send_word(8'h22); tick();
    tests_run++;
    if (fill !== 3'd2 || out_data !== 8'h21) begin
      tests_failed++;
      $display("[TB] FAIL conc_setup: fill=%0d head=%h, expected 2 and 21", fill, out_data);
    end
    send_word(8'h33);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run += 3;
    if (fill !== 3'd2)       begin tests_failed++; $display("[TB] FAIL conc_fill: got %0d, expected 2", fill); end
    if (out_data !== 8'h22)  begin tests_failed++; $display("[TB] FAIL conc_head: got %h, expected 22", out_data); end
    if (ack_tgl !== req_tgl) begin tests_failed++; $display("[TB] FAIL conc_ack: got %b, expected %b", ack_tgl, req_tgl); end
    drain();
  endtask

  task automatic test_wrap();
    int pops_before;
    int over;
    pops_before = pop_count;
    over = 0;
    out_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      send_word(8'(w));
      tick();
      if (fill > 3'd1) over++;
    end
    tests_run++;
    if (over != 0) begin tests_failed++; $display("[TB] FAIL wrap_fill: %0d cycles above 1, expected 0", over); end
    drain();
    tests_run++;
    if (pop_count - pops_before != 16) begin
      tests_failed++;
      $display("[TB] FAIL wrap_count: got %0d words, expected 16", pop_count - pops_before);
    end
  endtask

  task automatic test_random();
    int pops_before;
    bit sender_done;
    pops_before = pop_count;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send_word(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) tick();
        end
        sender_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          if (sender_done && sb.size() == 0) break;
        end
        out_ready = 1'b0;
      end
    join
    tests_run += 2;
    if (sb.size() != 0) begin tests_failed++; $display("[TB] FAIL random_leftover: got %0d words, expected 0", sb.size()); end
    if (pop_count - pops_before != 1000) begin
      tests_failed++;
      $display("[TB] FAIL random_count: got %0d words, expected 1000", pop_count - pops_before);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    pop_count = 0;
    test_reset();
    test_single();
    test_full();
    test_concurrent();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
